ssd_scan_capture: RTL and testbench

- Receive-side counterpart of the team's 4-digit multiplexed seven-segment scanner.
- Samples the scanned COM_1..COM_4 digit enables and a..g segment lines as they appear at the display pins.
- Filters switching glitches, decodes each stable segment pattern back to a hex nibble, and publishes a 16-bit frame once all four digits are seen.
- Used as a board-level monitor and as a self-check block behind the display driver.

---
 rtl/ssd_pkg.sv | 32 +++
 rtl/ssd_seg2hex.sv | 36 +++
 rtl/ssd_scan_capture.sv | 196 +++++++++++++++++++
 tb/tb_ssd_scan_capture.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/ssd_pkg.sv
// Shared definitions for the seven-segment scan capture block.
// Segment codes, bus widths and frame FSM states.
package ssd_pkg;

  localparam int NDIG  = 4;
  localparam int COM_W = 4;
  localparam int SEG_W = 7;

  // Segment codes, seg[6:0] = {a,b,c,d,e,f,g}
  localparam logic [SEG_W-1:0] SEG_0 = 7'h7E;
  localparam logic [SEG_W-1:0] SEG_1 = 7'h30;
  localparam logic [SEG_W-1:0] SEG_2 = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_3 = 7'h79;
  localparam logic [SEG_W-1:0] SEG_4 = 7'h33;
  localparam logic [SEG_W-1:0] SEG_5 = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_6 = 7'h5F;
  localparam logic [SEG_W-1:0] SEG_7 = 7'h70;
  localparam logic [SEG_W-1:0] SEG_8 = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9 = 7'h7B;
  localparam logic [SEG_W-1:0] SEG_A = 7'h77;
  localparam logic [SEG_W-1:0] SEG_B = 7'h1F;
  localparam logic [SEG_W-1:0] SEG_C = 7'h4E;
  localparam logic [SEG_W-1:0] SEG_D = 7'h3D;
  localparam logic [SEG_W-1:0] SEG_E = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_F = 7'h47;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

endpackage

// File: rtl/ssd_seg2hex.sv
// Seven-segment pattern to hex nibble decoder.
// o_ok is low for any pattern outside the 16 glyphs.
module ssd_seg2hex
  import ssd_pkg::*;
(
  input  logic [SEG_W-1:0] i_seg,
  output logic             o_ok,
  output logic [3:0]       o_nib
);

  // Pure table lookup; unknown glyphs report nibble 0 with o_ok low
  always_comb begin
    o_ok  = 1'b1;
    o_nib = 4'h0;
    case (i_seg)
      SEG_0:   o_nib = 4'h0;
      SEG_1:   o_nib = 4'h1;
      SEG_2:   o_nib = 4'h2;
      SEG_3:   o_nib = 4'h3;
      SEG_4:   o_nib = 4'h4;
      SEG_5:   o_nib = 4'h5;
      SEG_6:   o_nib = 4'h6;
      SEG_7:   o_nib = 4'h7;
      SEG_8:   o_nib = 4'h8;
      SEG_9:   o_nib = 4'h9;
      SEG_A:   o_nib = 4'hA;
      SEG_B:   o_nib = 4'hB;
      SEG_C:   o_nib = 4'hC;
      SEG_D:   o_nib = 4'hD;
      SEG_E:   o_nib = 4'hE;
      SEG_F:   o_nib = 4'hF;
      default: o_ok  = 1'b0;
    endcase
  end

endmodule

// File: rtl/ssd_scan_capture.sv
// Captures a multiplexed 4-digit seven-segment display from its pins.
// Sync, glitch filter, decode, frame assembly and timeout.
module ssd_scan_capture
  import ssd_pkg::*;
#(
  parameter int STABLE_CNT = 4,
  parameter int TIMEOUT    = 1023
) (
  input  logic                Clk,
  input  logic                Aclr,
  input  logic [COM_W-1:0]    com,
  input  logic [SEG_W-1:0]    seg,
  output logic [4*NDIG-1:0]   digits,
  output logic [NDIG-1:0]     digit_ok,
  output logic                frame_valid,
  output logic                frame_strobe,
  output logic                com_err,
  output logic                timeout
);

  localparam logic [3:0]  SC = 4'(STABLE_CNT);
  localparam logic [15:0] TO = 16'(TIMEOUT);

  logic [COM_W-1:0] r_com_s1, r_com_s2;
  logic [SEG_W-1:0] r_seg_s1, r_seg_s2;

  logic       w_one;
  logic       w_blank;
  logic       w_illegal;
  logic [1:0] w_idx;
  logic       w_ok;
  logic [3:0] w_nib;
  logic       w_match;
  logic [3:0] w_cnt_n;
  logic       w_fire;

  logic             r_kv;
  logic [1:0]       r_kidx;
  logic [SEG_W-1:0] r_kseg;
  logic             r_kok;
  logic [3:0]       r_knib;
  logic [3:0]       r_cnt;
  logic             r_cap;

  state_t     r_state, w_state_n;
  logic [3:0] r_seen, w_seen_n, w_seen_or;
  logic [15:0] r_tcnt, w_tcnt_n, w_tcnt_inc;
  logic       w_fv_n, w_fs_n, w_to_n;

  // Two-flop synchroniser on the display pins
  always_ff @(posedge Clk or negedge Aclr) begin
    if (!Aclr) begin
      r_com_s1 <= 4'hF;
      r_com_s2 <= 4'hF;
      r_seg_s1 <= 7'h00;
      r_seg_s2 <= 7'h00;
    end else begin
      r_com_s1 <= com;
      r_com_s2 <= r_com_s1;
      r_seg_s1 <= seg;
      r_seg_s2 <= r_seg_s1;
    end
  end

  // Classify the synced COM sample: single digit, blank or illegal
  always_comb begin
    w_one = 1'b1;
    w_idx = 2'd0;
    case (r_com_s2)
      4'b1110: w_idx = 2'd0;
      4'b1101: w_idx = 2'd1;
      4'b1011: w_idx = 2'd2;
      4'b0111: w_idx = 2'd3;
      default: w_one = 1'b0;
    endcase
  end

  assign w_blank   = (r_com_s2 == 4'hF);
  assign w_illegal = !w_one && !w_blank;

  ssd_seg2hex u_dec (
    .i_seg (r_seg_s2),
    .o_ok  (w_ok),
    .o_nib (w_nib)
  );

  // Dwell length of the current {digit, pattern}; fire once at threshold
  always_comb begin
    w_match = r_kv && (w_idx == r_kidx) && (r_seg_s2 == r_kseg);
    w_cnt_n = 4'd0;
    if (w_one) begin
      if (w_match)
        w_cnt_n = (r_cnt == SC) ? SC : r_cnt + 4'd1;
      else
        w_cnt_n = 4'd1;
    end
    w_fire = w_one && (w_cnt_n == SC) && (r_cnt != SC);
  end

  // Stability tracker and the registered capture request
  always_ff @(posedge Clk or negedge Aclr) begin
    if (!Aclr) begin
      r_kv    <= 1'b0;
      r_kidx  <= 2'd0;
      r_kseg  <= 7'h00;
      r_kok   <= 1'b0;
      r_knib  <= 4'h0;
      r_cnt   <= 4'd0;
      r_cap   <= 1'b0;
      com_err <= 1'b0;
    end else begin
      r_kv    <= w_one;
      r_kidx  <= w_idx;
      r_kseg  <= r_seg_s2;
      r_kok   <= w_ok;
      r_knib  <= w_nib;
      r_cnt   <= w_cnt_n;
      r_cap   <= w_fire;
      com_err <= w_illegal;
    end
  end

  // Captured digit values and their recognised flags
  always_ff @(posedge Clk or negedge Aclr) begin
    if (!Aclr) begin
      digits   <= '0;
      digit_ok <= '0;
    end else if (r_cap) begin
      if (r_kok)
        digits[{r_kidx, 2'b00} +: 4] <= r_knib;
      digit_ok[r_kidx] <= r_kok;
    end
  end

  // Frame FSM state register
  always_ff @(posedge Clk or negedge Aclr) begin
    if (!Aclr) begin
      r_state      <= IDLE;
      r_seen       <= 4'h0;
      r_tcnt       <= 16'd0;
      frame_valid  <= 1'b0;
      frame_strobe <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_seen       <= w_seen_n;
      r_tcnt       <= w_tcnt_n;
      frame_valid  <= w_fv_n;
      frame_strobe <= w_fs_n;
      timeout      <= w_to_n;
    end
  end

  // Frame FSM next state: collect digits, strobe on full mask, time out
  always_comb begin
    w_state_n  = r_state;
    w_seen_n   = r_seen;
    w_tcnt_n   = r_tcnt;
    w_fv_n     = frame_valid;
    w_fs_n     = 1'b0;
    w_to_n     = 1'b0;
    w_seen_or  = r_seen | (4'b0001 << r_kidx);
    w_tcnt_inc = r_tcnt + 16'd1;
    unique case (r_state)
      IDLE: begin
        if (r_cap) begin
          w_state_n = COLLECT;
          w_seen_n  = w_seen_or;
          w_tcnt_n  = 16'd0;
        end
      end
      COLLECT: begin
        if (r_cap) begin
          w_tcnt_n = 16'd0;
          if (w_seen_or == 4'hF) begin
            w_fs_n   = 1'b1;
            w_fv_n   = 1'b1;
            w_seen_n = 4'h0;
          end else begin
            w_seen_n = w_seen_or;
          end
        end else if (w_tcnt_inc == TO) begin
          w_to_n    = 1'b1;
          w_fv_n    = 1'b0;
          w_seen_n  = 4'h0;
          w_tcnt_n  = 16'd0;
          w_state_n = IDLE;
        end else begin
          w_tcnt_n = w_tcnt_inc;
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ssd_scan_capture.sv
// Testbench for ssd_scan_capture.
// Event-level reference model checked every cycle plus literal checks.
module tb_ssd_scan_capture;

  localparam int SC = 4;
  localparam int TO = 1023;

  logic        Clk = 1'b0;
  logic        Aclr = 1'b0;
  logic [3:0]  com = 4'hF;
  logic [6:0]  seg = 7'h00;
  logic [15:0] digits;
  logic [3:0]  digit_ok;
  logic        frame_valid, frame_strobe, com_err, timeout;

  ssd_scan_capture #(.STABLE_CNT(SC), .TIMEOUT(TO)) dut (
    .Clk          (Clk),
    .Aclr         (Aclr),
    .com          (com),
    .seg          (seg),
    .digits       (digits),
    .digit_ok     (digit_ok),
    .frame_valid  (frame_valid),
    .frame_strobe (frame_strobe),
    .com_err      (com_err),
    .timeout      (timeout)
  );

  always #5 Clk = ~Clk;

  int n_chk = 0;
  int n_fail = 0;
  int strobes = 0, timeouts = 0, errs = 0;

  logic [6:0] codes [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B,
                             7'h5F, 7'h70, 7'h7F, 7'h7B, 7'h77, 7'h1F,
                             7'h4E, 7'h3D, 7'h4F, 7'h47};

  // model state
  logic [15:0] m_dig;
  logic [3:0]  m_ok, m_seen;
  logic        m_fv, m_fs, m_err, m_to, m_collect;
  int          m_tcnt, run, edge_n;
  logic        p_legal;
  int          p_idx;
  logic [6:0]  p_seg;
  bit          ev_cap [8];
  int          ev_idx [8];
  logic [6:0]  ev_seg [8];
  bit          ev_err [8];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic m_reset();
    m_dig = 0; m_ok = 0; m_seen = 0;
    m_fv = 0; m_fs = 0; m_err = 0; m_to = 0; m_collect = 0;
    m_tcnt = 0; run = 0; edge_n = 0;
    p_legal = 0; p_idx = 0; p_seg = 0;
    for (int i = 0; i < 8; i++) begin
      ev_cap[i] = 0; ev_err[i] = 0; ev_idx[i] = 0; ev_seg[i] = 0;
    end
  endtask

  // One clock edge of the reference model, given the pins sampled there.
  task automatic m_edge(input logic [3:0] c, input logic [6:0] s);
    int slot, zeros, idx, hit;
    slot = edge_n % 8;
    m_fs = 0; m_to = 0;
    m_err = ev_err[slot];
    ev_err[slot] = 0;
    if (ev_cap[slot]) begin
      ev_cap[slot] = 0;
      hit = -1;
      for (int i = 0; i < 16; i++) if (codes[i] == ev_seg[slot]) hit = i;
      if (hit >= 0) begin
        m_dig[ev_idx[slot]*4 +: 4] = 4'(hit);
        m_ok[ev_idx[slot]] = 1;
      end else begin
        m_ok[ev_idx[slot]] = 0;
      end
      m_tcnt = 0;
      m_seen[ev_idx[slot]] = 1;
      m_collect = 1;
      if (m_seen == 4'hF) begin
        m_fs = 1; m_fv = 1; m_seen = 0;
      end
    end else if (m_collect) begin
      m_tcnt++;
      if (m_tcnt == TO) begin
        m_to = 1; m_fv = 0; m_seen = 0; m_collect = 0; m_tcnt = 0;
      end
    end
    zeros = 0; idx = 0;
    for (int i = 0; i < 4; i++) if (!c[i]) begin zeros++; idx = i; end
    if (zeros == 1) begin
      if (p_legal && idx == p_idx && s == p_seg) run++;
      else run = 1;
      p_legal = 1; p_idx = idx; p_seg = s;
      if (run == SC) begin
        ev_cap[(edge_n+3)%8] = 1;
        ev_idx[(edge_n+3)%8] = idx;
        ev_seg[(edge_n+3)%8] = s;
      end
    end else begin
      run = 0; p_legal = 0;
      if (zeros >= 2) ev_err[(edge_n+2)%8] = 1;
    end
    edge_n++;
  endtask

  task automatic check_all();
    chk("digits", 32'(digits), 32'(m_dig));
    chk("digit_ok", 32'(digit_ok), 32'(m_ok));
    chk("frame_valid", 32'(frame_valid), 32'(m_fv));
    chk("frame_strobe", 32'(frame_strobe), 32'(m_fs));
    chk("com_err", 32'(com_err), 32'(m_err));
    chk("timeout", 32'(timeout), 32'(m_to));
    if (frame_strobe === 1'b1) strobes++;
    if (timeout === 1'b1) timeouts++;
    if (com_err === 1'b1) errs++;
  endtask

  task automatic cyc(input logic a, input logic [3:0] c,
                     input logic [6:0] s);
    @(negedge Clk);
    Aclr = a; com = c; seg = s;
    @(posedge Clk);
    if (Aclr) m_edge(c, s);
    else m_reset();
    #1 check_all();
  endtask

  task automatic dwell(input logic [3:0] c, input logic [6:0] s,
                       input int n);
    repeat (n) cyc(1'b1, c, s);
  endtask

  int s0, t0;

  initial begin
    m_reset();
    // reset held with random pins
    for (int i = 0; i < 6; i++)
      cyc(1'b0, 4'($urandom), 7'($urandom));
    chk("rst_digits", 32'(digits), 32'h0);
    chk("rst_flags", {28'h0, frame_valid, frame_strobe, com_err, timeout},
        32'h0);

    // normal scan 1,2,3,4
    s0 = strobes;
    dwell(4'b1110, 7'h30, 8);
    dwell(4'b1101, 7'h6D, 8);
    dwell(4'b1011, 7'h79, 8);
    dwell(4'b0111, 7'h33, 8);
    dwell(4'hF, 7'h00, 4);
    chk("scan_digits", 32'(digits), 32'h4321);
    chk("scan_ok", 32'(digit_ok), 32'hF);
    chk("scan_fv", 32'(frame_valid), 32'h1);
    chk("scan_strobes", 32'(strobes - s0), 32'd1);

    // glitch shorter than the filter
    dwell(4'b1101, 7'h6D, 8);
    dwell(4'b1101, 7'h7F, 2);
    dwell(4'hF, 7'h00, 4);
    chk("glitch_held", 32'(digits[7:4]), 32'h2);
    dwell(4'b1101, 7'h7F, 6);
    dwell(4'hF, 7'h00, 4);
    chk("glitch_long", 32'(digits[7:4]), 32'h8);

    // illegal com
    t0 = errs;
    dwell(4'b0011, 7'h30, 5);
    dwell(4'hF, 7'h00, 4);
    chk("illegal_err", 32'(errs - t0 > 0), 32'h1);
    chk("illegal_digits", 32'(digits), 32'h4381);

    // unrecognised pattern on COM_2, frame still completes
    s0 = strobes;
    dwell(4'b1101, 7'h01, 8);
    dwell(4'b1110, 7'h30, 8);
    dwell(4'b1011, 7'h79, 8);
    dwell(4'b0111, 7'h33, 8);
    dwell(4'hF, 7'h00, 4);
    chk("unrec_ok", 32'(digit_ok), 32'hD);
    chk("unrec_digits", 32'(digits), 32'h4381);
    chk("unrec_strobe", 32'(strobes - s0), 32'd1);

    // timeout
    t0 = timeouts;
    dwell(4'hF, 7'h00, TO + 8);
    chk("to_pulses", 32'(timeouts - t0), 32'd1);
    chk("to_fv", 32'(frame_valid), 32'h0);
    chk("to_digits", 32'(digits), 32'h4381);

    // reset mid-scan, asynchronous clear
    dwell(4'b1110, 7'h7E, 8);
    dwell(4'b1101, 7'h77, 3);
    @(negedge Clk);
    Aclr = 1'b0;
    #1;
    chk("arst_digits", 32'(digits), 32'h0);
    chk("arst_ok", 32'(digit_ok), 32'h0);
    chk("arst_flags", {28'h0, frame_valid, frame_strobe, com_err, timeout},
        32'h0);
    m_reset();
    @(posedge Clk);
    #1 check_all();

    // fresh scan after release; a 3-cycle dwell is below threshold
    s0 = strobes;
    dwell(4'b1110, 7'h47, 3);
    dwell(4'b1110, 7'h7E, 8);
    dwell(4'b1101, 7'h77, 8);
    dwell(4'b1011, 7'h1F, 8);
    dwell(4'b0111, 7'h4E, 8);
    dwell(4'hF, 7'h00, 4);
    chk("post_digits", 32'(digits), 32'hCBA0);
    chk("post_strobe", 32'(strobes - s0), 32'd1);
    chk("post_fv", 32'(frame_valid), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
